demux_tdm8: RTL and testbench

//   Receive-side 1-to-8 time-division demultiplexer: pairs with the 8-to-1 mux on the transmit side.

---
 rtl/demux_tdm8_pkg.sv | 19 +
 rtl/tdm_slot_counter.sv | 34 +++
 rtl/demux_tdm8.sv | 114 +++++++++++
 tb/tb_demux_tdm8.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_tdm8_pkg.sv
// Shared constants and types for the 8-slot TDM receive demultiplexer.
package demux_tdm8_pkg;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SLOT_W-1:0] SLOT_A = 3'd0;
    localparam logic [SLOT_W-1:0] SLOT_B = 3'd1;
    localparam logic [SLOT_W-1:0] SLOT_C = 3'd2;
    localparam logic [SLOT_W-1:0] SLOT_D = 3'd3;
    localparam logic [SLOT_W-1:0] SLOT_E = 3'd4;
    localparam logic [SLOT_W-1:0] SLOT_F = 3'd5;
    localparam logic [SLOT_W-1:0] SLOT_G = 3'd6;
    localparam logic [SLOT_W-1:0] SLOT_H = 3'd7;
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: load-to-1 after a sync sample, otherwise increments and wraps 7->0.
module tdm_slot_counter
    import demux_tdm8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o,
    output logic              last_o
);
    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load1_i) begin
            cnt_d = SLOT_B;
        end else if (inc_i) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= SLOT_A;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_o = cnt_q;
    assign last_o = (cnt_q == SLOT_H);
endmodule

// File: rtl/demux_tdm8.sv
// 1-to-8 TDM demultiplexer: collects slot-serial samples into a shadow frame and
// presents each completed frame as one parallel word behind a valid/ready handshake.
module demux_tdm8
    import demux_tdm8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sync,
    input  logic                 out_ready,
    input  logic                 clr_ovf,
    output logic                 out_valid,
    output logic [8*WIDTH-1:0]   out_data,
    output logic [SLOT_W-1:0]    slot,
    output logic                 locked,
    output logic                 sync_err,
    output logic                 overflow
);
    state_t                state_q;
    logic [WIDTH-1:0]      shadow_q [NUM_SLOTS-1];
    logic                  out_valid_q;
    logic [8*WIDTH-1:0]    out_data_q;
    logic                  sync_err_q;
    logic                  ovf_q;

    logic [SLOT_W-1:0]     slot_cur;
    logic                  slot_last;
    logic                  in_run;
    logic                  start_hunt;
    logic                  resync;
    logic                  load1;
    logic                  adv;
    logic                  complete;
    logic                  accept;
    logic                  can_load;
    logic [8*WIDTH-1:0]    frame_word;

    tdm_slot_counter u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .load1_i (load1),
        .inc_i   (adv),
        .slot_o  (slot_cur),
        .last_o  (slot_last)
    );

    // A sync sample always lands in lane a; in RUN it only counts as an error off slot 0.
    always_comb begin
        in_run     = (state_q == RUN);
        start_hunt = !in_run && in_valid && in_sync;
        resync     = in_run && in_valid && in_sync && (slot_cur != SLOT_A);
        load1      = start_hunt || resync;
        adv        = in_run && in_valid && !resync;
        complete   = adv && slot_last;
        accept     = out_valid_q && out_ready;
        can_load   = !out_valid_q || out_ready;
    end

    // Lane h never touches the shadow: it comes straight from the completing sample.
    always_comb begin
        frame_word = '0;
        for (int k = 0; k < NUM_SLOTS - 1; k++) begin
            frame_word[k*WIDTH +: WIDTH] = shadow_q[k];
        end
        frame_word[(NUM_SLOTS-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sync_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
            for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            if (load1) begin
                state_q <= RUN;
            end
            sync_err_q <= resync;

            if (load1) begin
                shadow_q[0] <= in_data;
            end else if (adv && !slot_last) begin
                shadow_q[slot_cur] <= in_data;
            end

            if (complete && can_load) begin
                out_data_q  <= frame_word;
                out_valid_q <= 1'b1;
            end else if (accept) begin
                out_valid_q <= 1'b0;
            end

            if (complete && !can_load) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign slot      = slot_cur;
    assign locked    = (state_q == RUN);
    assign sync_err  = sync_err_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_demux_tdm8.sv
// Directed bench for demux_tdm8: a WIDTH=4 instance driven by a vector table and
// hand-written sequences, plus a WIDTH=1 instance for the single-bit framing case.
module tb_demux_tdm8;
    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_sync, out_ready, clr_ovf;
    logic [3:0]  in_data;
    logic        out_valid, locked, sync_err, overflow;
    logic [31:0] out_data;
    logic [2:0]  slot;

    logic        in_valid1, in_sync1;
    logic [0:0]  in_data1;
    logic        out_valid1, locked1, sync_err1, overflow1;
    logic [7:0]  out_data1;
    logic [2:0]  slot1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_tdm8 #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sync(in_sync),
        .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid), .out_data(out_data),
        .slot(slot), .locked(locked), .sync_err(sync_err), .overflow(overflow)
    );

    demux_tdm8 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1), .in_sync(in_sync1),
        .out_ready(1'b1), .clr_ovf(1'b0), .out_valid(out_valid1), .out_data(out_data1),
        .slot(slot1), .locked(locked1), .sync_err(sync_err1), .overflow(overflow1)
    );

    typedef struct {
        logic        v;
        logic        s;
        logic [3:0]  d;
        logic        rdy;
        logic [2:0]  e_slot;
        logic        e_ov;
        logic [31:0] e_data;
        logic        e_ovf;
        logic        e_err;
        logic        e_lock;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(logic v, logic s, logic [3:0] d, logic rdy, logic [2:0] e_slot,
                                logic e_ov, logic [31:0] e_data, logic e_ovf, logic e_err,
                                logic e_lock);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.rdy = rdy; r.e_slot = e_slot; r.e_ov = e_ov;
        r.e_data = e_data; r.e_ovf = e_ovf; r.e_err = e_err; r.e_lock = e_lock;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sync  = s;
        tick();
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] base, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) clr_ovf = clr_last;
            send(base + 4'(i), (i == 0));
            clr_ovf = 1'b0;
        end
    endtask

    task automatic send1(input logic b, input logic s);
        in_valid1   = 1'b1;
        in_data1[0] = b;
        in_sync1    = s;
        tick();
        in_valid1   = 1'b0;
        in_sync1    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] bits1;
        rst = 1'b1;
        in_valid = 0; in_sync = 0; in_data = '0; out_ready = 0; clr_ovf = 0;
        in_valid1 = 0; in_sync1 = 0; in_data1 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_slot", 32'(slot), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);
        chk("reset_err", 32'(sync_err), 32'd0);

        // Table: two back-to-back WIDTH=4 frames, ready asserted only when frame 2 completes.
        tbl[0]  = mk(1, 1, 4'h1, 0, 3'd1, 0, 32'h0, 0, 0, 1);
        tbl[1]  = mk(1, 0, 4'h2, 0, 3'd2, 0, 32'h0, 0, 0, 1);
        tbl[2]  = mk(1, 0, 4'h3, 0, 3'd3, 0, 32'h0, 0, 0, 1);
        tbl[3]  = mk(1, 0, 4'h4, 0, 3'd4, 0, 32'h0, 0, 0, 1);
        tbl[4]  = mk(1, 0, 4'h5, 0, 3'd5, 0, 32'h0, 0, 0, 1);
        tbl[5]  = mk(1, 0, 4'h6, 0, 3'd6, 0, 32'h0, 0, 0, 1);
        tbl[6]  = mk(1, 0, 4'h7, 0, 3'd7, 0, 32'h0, 0, 0, 1);
        tbl[7]  = mk(1, 0, 4'h8, 0, 3'd0, 1, 32'h87654321, 0, 0, 1);
        tbl[8]  = mk(1, 1, 4'h9, 0, 3'd1, 1, 32'h87654321, 0, 0, 1);
        tbl[9]  = mk(1, 0, 4'hA, 0, 3'd2, 1, 32'h87654321, 0, 0, 1);
        tbl[10] = mk(1, 0, 4'hB, 0, 3'd3, 1, 32'h87654321, 0, 0, 1);
        tbl[11] = mk(1, 0, 4'hC, 0, 3'd4, 1, 32'h87654321, 0, 0, 1);
        tbl[12] = mk(1, 0, 4'hD, 0, 3'd5, 1, 32'h87654321, 0, 0, 1);
        tbl[13] = mk(1, 0, 4'hE, 0, 3'd6, 1, 32'h87654321, 0, 0, 1);
        tbl[14] = mk(1, 0, 4'hF, 0, 3'd7, 1, 32'h87654321, 0, 0, 1);
        tbl[15] = mk(1, 0, 4'h0, 1, 3'd0, 1, 32'h0FEDCBA9, 0, 0, 1);
        tbl[16] = mk(0, 0, 4'h0, 1, 3'd0, 0, 32'h0FEDCBA9, 0, 0, 1);

        for (int i = 0; i < 17; i++) begin
            in_valid  = tbl[i].v;
            in_sync   = tbl[i].s;
            in_data   = tbl[i].d;
            out_ready = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_slot", i), 32'(slot), 32'(tbl[i].e_slot));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
            chk($sformatf("vec%0d_err", i), 32'(sync_err), 32'(tbl[i].e_err));
            chk($sformatf("vec%0d_lock", i), 32'(locked), 32'(tbl[i].e_lock));
        end
        in_valid = 0; in_sync = 0; out_ready = 0;

        // WIDTH=1: pre-sync samples ignored, then framing of 1,0,1,1,0,0,1,0.
        do_reset();
        send1(1'b1, 1'b0);
        send1(1'b1, 1'b0);
        chk("w1_presync_slot", 32'(slot1), 32'd0);
        chk("w1_presync_lock", 32'(locked1), 32'd0);
        bits1 = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            send1(bits1[i], (i == 0));
        end
        chk("w1_valid", 32'(out_valid1), 32'd1);
        chk("w1_data", 32'(out_data1), 32'h4D);
        chk("w1_lock", 32'(locked1), 32'd1);

        // Overflow: held word, sticky flag, clear, and set-over-clear priority.
        do_reset();
        out_ready = 0;
        send_frame(4'h1, 1'b0);
        chk("ovf_first_valid", 32'(out_valid), 32'd1);
        chk("ovf_first_flag", 32'(overflow), 32'd0);
        send_frame(4'h9, 1'b0);
        chk("ovf_held_data", out_data, 32'h87654321);
        chk("ovf_set", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);
        send_frame(4'h3, 1'b1);
        chk("ovf_set_beats_clr", 32'(overflow), 32'd1);
        chk("ovf_held_data2", out_data, 32'h87654321);

        // Mid-frame sync at slot 5.
        do_reset();
        out_ready = 1;
        send(4'h1, 1); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0); send(4'h5, 0);
        chk("resync_pre_slot", 32'(slot), 32'd5);
        send(4'hA, 1);
        chk("resync_err_pulse", 32'(sync_err), 32'd1);
        chk("resync_slot", 32'(slot), 32'd1);
        chk("resync_no_valid", 32'(out_valid), 32'd0);
        tick();
        chk("resync_err_clear", 32'(sync_err), 32'd0);
        send(4'hB, 0); send(4'hC, 0); send(4'hD, 0); send(4'hE, 0); send(4'hF, 0); send(4'h1, 0);
        chk("resync_partial_valid", 32'(out_valid), 32'd0);
        send(4'h2, 0);
        chk("resync_valid", 32'(out_valid), 32'd1);
        chk("resync_data", out_data, 32'h21FEDCBA);
        chk("resync_lock", 32'(locked), 32'd1);

        // Random gaps between slots give the same word as the gapless frame.
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            while ($urandom_range(0, 1) == 1) tick();
            if (i == 7) chk("gap_pre_valid", 32'(out_valid), 32'd0);
            send(4'(i + 1), (i == 0));
        end
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_data", out_data, 32'h87654321);

        // Asynchronous reset mid-frame and while holding output.
        do_reset();
        send(4'h1, 1); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
        chk("rst_pre_slot", 32'(slot), 32'd4);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_slot", 32'(slot), 32'd0);
        chk("rst_async_lock", 32'(locked), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 0;
        send_frame(4'h1, 1'b0);
        send_frame(4'h9, 1'b0);
        chk("rst_pre_ovf", 32'(overflow), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'd0);
        chk("rst_async_data", out_data, 32'd0);
        chk("rst_async_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send(4'h5, 0);
        chk("rst_hunt_slot", 32'(slot), 32'd0);
        chk("rst_hunt_lock", 32'(locked), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
